// File: rtl/conv_line_buffer_pkg.sv
// Shared defaults, FSM encoding and slot arithmetic for the raster-to-column line buffer.
// Keep the defaults aligned with Convolution_Controller so the column order matches its data port.
package conv_line_buffer_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_MAX_WIDTH   = 1024;
  localparam int DEF_DIM_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  // Physical slot that holds the row sitting 'offs' rows after the row in slot 'base'.
  function automatic int unsigned slot_wrap(input int unsigned base, input int unsigned offs,
                                            input int unsigned slots);
    return (base + offs) % slots;
  endfunction

endpackage

// File: rtl/conv_line_buffer_line_mem.sv
// Row-slot line memory: SLOTS rows of DEPTH words each, synchronous write into one slot,
// asynchronous read of every slot at the same column address.
module conv_line_buffer_line_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int SLOTS      = 2,
  parameter int DEPTH      = 1024,
  parameter int AW         = $clog2(DEPTH),
  parameter int SW         = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [SW-1:0]                     wslot,
  input  logic [AW-1:0]                     addr,
  input  logic [DATA_WIDTH-1:0]             wdata,
  output logic [SLOTS-1:0][DATA_WIDTH-1:0]  rdata
);

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (we && (wslot == SW'(gi))) begin
          mem[addr] <= wdata;
        end
      end

      assign rdata[gi] = mem[addr];
    end
  endgenerate

endmodule

// File: rtl/conv_line_buffer.sv
// Raster-to-column window feeder: stores the previous KERNEL_SIZE-1 rows and, for every pixel
// from row KERNEL_SIZE-1 onward, emits its vertical column oldest row first.
module conv_line_buffer
  import conv_line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int MAX_WIDTH   = DEF_MAX_WIDTH,
  parameter int DIM_WIDTH   = DEF_DIM_WIDTH
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset_n,
  input  logic                      enable,
  input  logic                      soft_reset,
  input  logic [DIM_WIDTH-1:0]      img_width,
  input  logic [DIM_WIDTH-1:0]      img_height,
  input  logic                      s_axis_valid,
  output logic                      s_axis_ready,
  input  logic [DATA_WIDTH-1:0]     s_axis_data,
  input  logic                      s_axis_last,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_keep,
  output logic                      m_axis_valid,
  input  logic                      m_axis_ready,
  output logic [DATA_WIDTH-1:0]     m_axis_data,
  output logic                      m_axis_last,
  output logic [DATA_WIDTH/8-1:0]   m_axis_keep,
  output logic                      frame_done,
  output logic                      frame_err,
  output logic                      cfg_err
);

  localparam int SLOTS = KERNEL_SIZE - 1;
  localparam int AW    = $clog2(MAX_WIDTH);
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int BW    = (KERNEL_SIZE > 2) ? $clog2(KERNEL_SIZE) : 1;

  state_t                  state_reg;
  logic [DIM_WIDTH-1:0]    x_reg, y_reg, w_reg, h_reg;
  logic [SW-1:0]           slot_reg;
  logic [BW-1:0]           b_reg;
  logic [DATA_WIDTH-1:0]   hold_reg [KERNEL_SIZE];
  logic                    valid_reg, ready_reg, done_reg, err_reg, end_reg;

  logic [SLOTS-1:0][DATA_WIDTH-1:0] rd_rows;
  logic [DATA_WIDTH-1:0]   col [KERNEL_SIZE];
  logic [DIM_WIDTH-1:0]    cur_w, cur_h;
  logic                    cfg_ok, first_px, row_end, frame_end_pos, fill, s_fire, m_fire;
  logic                    unused_keep;

  assign unused_keep = ^s_axis_keep;

  assign cfg_ok = (img_width >= DIM_WIDTH'(KERNEL_SIZE)) && (img_width <= DIM_WIDTH'(MAX_WIDTH))
               && (img_height >= DIM_WIDTH'(KERNEL_SIZE));
  assign cfg_err = (state_reg == ST_IDLE) && !cfg_ok;

  // Dimensions are taken live on pixel (0,0) and from the latched copy for the rest of the frame.
  assign first_px      = (x_reg == '0) && (y_reg == '0);
  assign cur_w         = first_px ? img_width  : w_reg;
  assign cur_h         = first_px ? img_height : h_reg;
  assign row_end       = (x_reg == cur_w - DIM_WIDTH'(1));
  assign frame_end_pos = row_end && (y_reg == cur_h - DIM_WIDTH'(1));
  assign fill          = (y_reg < DIM_WIDTH'(SLOTS));
  assign s_fire        = ready_reg && s_axis_valid;
  assign m_fire        = valid_reg && m_axis_ready;

  conv_line_buffer_line_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLOTS      (SLOTS),
    .DEPTH      (MAX_WIDTH)
  ) u_line_mem (
    .clk   (axi_clk),
    .we    (s_fire),
    .wslot (slot_reg),
    .addr  (x_reg[AW-1:0]),
    .wdata (s_axis_data),
    .rdata (rd_rows)
  );

  // The slot about to be overwritten holds the oldest row, so the column starts there.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_col
      assign col[gi] = rd_rows[SW'(slot_wrap(32'(slot_reg), gi, SLOTS))];
    end
  endgenerate
  assign col[KERNEL_SIZE-1] = s_axis_data;

  assign s_axis_ready = ready_reg;
  assign m_axis_valid = valid_reg;
  assign m_axis_data  = hold_reg[b_reg];
  assign m_axis_last  = valid_reg && end_reg && (b_reg == BW'(KERNEL_SIZE-1));
  assign m_axis_keep  = '1;
  assign frame_done   = done_reg;
  assign frame_err    = err_reg;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_reg <= ST_IDLE;
      x_reg <= '0; y_reg <= '0; w_reg <= '0; h_reg <= '0;
      slot_reg <= '0; b_reg <= '0;
      valid_reg <= 1'b0; ready_reg <= 1'b0; done_reg <= 1'b0; err_reg <= 1'b0; end_reg <= 1'b0;
      for (int j = 0; j < KERNEL_SIZE; j++) hold_reg[j] <= '0;
    end else if (soft_reset) begin
      state_reg <= ST_IDLE;
      x_reg <= '0; y_reg <= '0; w_reg <= '0; h_reg <= '0;
      slot_reg <= '0; b_reg <= '0;
      valid_reg <= 1'b0; ready_reg <= 1'b0; done_reg <= 1'b0; err_reg <= 1'b0; end_reg <= 1'b0;
      for (int j = 0; j < KERNEL_SIZE; j++) hold_reg[j] <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (enable && cfg_ok) begin
            state_reg <= ST_ACCEPT;
            ready_reg <= 1'b1;
          end
        end
        ST_ACCEPT: begin
          if (s_fire) begin
            for (int j = 0; j < KERNEL_SIZE; j++) hold_reg[j] <= col[j];
            if (first_px) begin
              w_reg <= img_width;
              h_reg <= img_height;
            end
            if (s_axis_last != frame_end_pos) err_reg <= 1'b1;
            if (frame_end_pos || s_axis_last) begin
              x_reg <= '0; y_reg <= '0; slot_reg <= '0;
            end else if (row_end) begin
              x_reg    <= '0;
              y_reg    <= y_reg + DIM_WIDTH'(1);
              slot_reg <= (slot_reg == SW'(SLOTS-1)) ? '0 : slot_reg + SW'(1);
            end else begin
              x_reg <= x_reg + DIM_WIDTH'(1);
            end
            if (!fill) begin
              state_reg <= ST_EMIT;
              ready_reg <= 1'b0;
              valid_reg <= 1'b1;
              b_reg     <= '0;
              end_reg   <= frame_end_pos || s_axis_last;
            end else if (!enable) begin
              state_reg <= ST_IDLE;
              ready_reg <= 1'b0;
            end
          end else if (!enable) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (m_fire) begin
            if (b_reg == BW'(KERNEL_SIZE-1)) begin
              valid_reg <= 1'b0;
              b_reg     <= '0;
              done_reg  <= end_reg;
              end_reg   <= 1'b0;
              state_reg <= enable ? ST_ACCEPT : ST_IDLE;
              ready_reg <= enable;
            end else begin
              b_reg <= b_reg + BW'(1);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_line_buffer.sv
// Directed bench for conv_line_buffer: raster frames in, vertical columns out, compared
// against hand-derived constants and a small column model.
module tb_conv_line_buffer;

  localparam int DW = 8;

  logic            clk;
  logic            axi_reset_n, enable, soft_reset;
  logic [15:0]     img_width, img_height;
  logic            s_axis_valid, s_axis_ready, s_axis_last;
  logic [DW-1:0]   s_axis_data;
  logic [DW/8-1:0] s_axis_keep;
  logic            m_axis_valid, m_axis_ready, m_axis_last;
  logic [DW-1:0]   m_axis_data;
  logic [DW/8-1:0] m_axis_keep;
  logic            frame_done, frame_err, cfg_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] beat_data [$];
  logic       beat_last [$];
  int         done_at [$];
  logic [7:0] stall_data [$];
  logic       stall_sready [$];
  logic       en_obs [$];
  int         stall_at, stall_left, en_drop_at, en_off_left, rst_at;
  logic       timed_out, rst_fired, rst_pre_valid;
  logic       rst_valid, rst_last, rst_sready, rst_done, rst_err;
  logic [7:0] rst_data;

  conv_line_buffer #(
    .DATA_WIDTH(8), .KERNEL_SIZE(3), .MAX_WIDTH(1024), .DIM_WIDTH(16)
  ) dut (
    .axi_clk(clk), .axi_reset_n(axi_reset_n), .enable(enable), .soft_reset(soft_reset),
    .img_width(img_width), .img_height(img_height),
    .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready), .s_axis_data(s_axis_data),
    .s_axis_last(s_axis_last), .s_axis_keep(s_axis_keep),
    .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready), .m_axis_data(m_axis_data),
    .m_axis_last(m_axis_last), .m_axis_keep(m_axis_keep),
    .frame_done(frame_done), .frame_err(frame_err), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat i of a frame: pixel p = i/3 starting at row 2, beat b picks row y-2+b.
  function automatic logic [7:0] exp_beat(input int w, input int base, input int i);
    int p, b, x, y;
    p = i / 3; b = i % 3; x = p % w; y = 2 + p / w;
    return 8'((base + 16 * (y - 2 + b) + x) & 255);
  endfunction

  task automatic clear_obs();
    beat_data.delete(); beat_last.delete(); done_at.delete();
    stall_data.delete(); stall_sready.delete(); en_obs.delete();
    stall_at = -1; stall_left = 0; en_drop_at = -1; en_off_left = 0; rst_at = -1;
    timed_out = 1'b0; rst_fired = 1'b0; rst_pre_valid = 1'b0;
  endtask

  // Streams pixels (x,y) in raster order up to (lx,ly), value base+16y+x, last on (lx,ly).
  task automatic drive_frame(input int w, input int base, input int lx, input int ly);
    int n, idx, drain, cyc, x, y;
    n = ly * w + lx + 1;
    idx = 0; drain = 0; cyc = 0;
    while (drain < 12) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        timed_out = 1'b1; s_axis_valid = 1'b0;
        return;
      end
      if (rst_at >= 0 && beat_data.size() == rst_at && m_axis_valid) begin
        rst_pre_valid = m_axis_valid;
        axi_reset_n = 1'b0;
        #1;
        rst_valid = m_axis_valid; rst_last = m_axis_last; rst_data = m_axis_data;
        rst_sready = s_axis_ready; rst_done = frame_done; rst_err = frame_err;
        s_axis_valid = 1'b0; rst_at = -1; rst_fired = 1'b1;
        return;
      end
      if (en_drop_at >= 0 && beat_data.size() == en_drop_at && m_axis_valid) begin
        enable = 1'b0; en_off_left = 5; en_drop_at = -1;
      end
      if (!enable && en_off_left > 0 && !m_axis_valid) begin
        en_obs.push_back(s_axis_ready);
        en_off_left--;
        if (en_off_left == 0) enable = 1'b1;
      end
      if (m_axis_valid && beat_data.size() == stall_at && stall_left > 0) begin
        m_axis_ready = 1'b0;
        stall_left--;
        stall_data.push_back(m_axis_data);
        stall_sready.push_back(s_axis_ready);
      end else begin
        m_axis_ready = 1'b1;
      end
      if (frame_done) done_at.push_back(beat_data.size());
      if (m_axis_valid && m_axis_ready) begin
        beat_data.push_back(m_axis_data);
        beat_last.push_back(m_axis_last);
      end
      if (idx < n) begin
        x = idx % w; y = idx / w;
        s_axis_valid = 1'b1;
        s_axis_data  = DW'((base + 16 * y + x) & 255);
        s_axis_last  = (x == lx) && (y == ly);
        if (s_axis_ready) idx++;
      end else begin
        s_axis_valid = 1'b0; s_axis_last = 1'b0;
        drain++;
      end
    end
    s_axis_valid = 1'b0; m_axis_ready = 1'b1;
  endtask

  task automatic test_reset();
    axi_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (s_axis_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_axis_ready); end
    checks++; if (m_axis_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_axis_valid); end
    checks++; if (m_axis_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b exp=0", m_axis_last); end
    checks++; if (m_axis_data !== 8'h00) begin failures++; $display("FAIL reset_m_data got=%h exp=00", m_axis_data); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    checks++; if (m_axis_keep !== 1'b1) begin failures++; $display("FAIL reset_m_keep got=%b exp=1", m_axis_keep); end
    axi_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (s_axis_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", s_axis_ready); end
    $display("test_reset done");
  endtask

  task automatic test_basic_frame();
    clear_obs();
    drive_frame(5, 0, 4, 3);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
    checks++; if (beat_data.size() != 30) begin failures++; $display("FAIL basic_count got=%0d exp=30", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 30; i++) begin
      checks++;
      if (beat_data[i] !== exp_beat(5, 0, i) || beat_last[i] !== (i == 29)) begin
        failures++;
        $display("FAIL basic_beat%0d got=%h/%b exp=%h/%b", i, beat_data[i], beat_last[i], exp_beat(5, 0, i), i == 29);
      end
    end
    checks++; if (beat_data.size() < 1 || beat_data[0] !== 8'h00) begin failures++; $display("FAIL basic_first_beat exp=00"); end
    checks++; if (beat_data.size() < 30 || beat_data[29] !== 8'h34) begin failures++; $display("FAIL basic_last_beat exp=34"); end
    checks++; if (done_at.size() != 1 || done_at[0] != 30) begin failures++; $display("FAIL basic_frame_done pulses=%0d exp=1 after beat 30", done_at.size()); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL basic_frame_err got=%b exp=0", frame_err); end
    $display("test_basic_frame beats=%0d", beat_data.size());
  endtask

  task automatic test_back_pressure();
    clear_obs();
    stall_at = 22; stall_left = 4;
    drive_frame(5, 0, 4, 3);
    checks++; if (stall_data.size() != 4) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=4", stall_data.size()); end
    for (int i = 0; i < stall_data.size(); i++) begin
      checks++;
      if (stall_data[i] !== 8'h22 || stall_sready[i] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got=%h ready=%b exp=22 ready=0", i, stall_data[i], stall_sready[i]);
      end
    end
    checks++; if (beat_data.size() != 30) begin failures++; $display("FAIL bp_count got=%0d exp=30", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 30; i++) begin
      checks++;
      if (beat_data[i] !== exp_beat(5, 0, i) || beat_last[i] !== (i == 29)) begin
        failures++;
        $display("FAIL bp_beat%0d got=%h/%b exp=%h/%b", i, beat_data[i], beat_last[i], exp_beat(5, 0, i), i == 29);
      end
    end
    $display("test_back_pressure beats=%0d", beat_data.size());
  endtask

  task automatic test_early_last();
    clear_obs();
    drive_frame(5, 0, 1, 2);
    checks++; if (beat_data.size() != 6) begin failures++; $display("FAIL early_count got=%0d exp=6", beat_data.size()); end
    if (beat_data.size() >= 6) begin
      checks++; if (beat_data[3] !== 8'h01) begin failures++; $display("FAIL early_beat3 got=%h exp=01", beat_data[3]); end
      checks++; if (beat_data[4] !== 8'h11) begin failures++; $display("FAIL early_beat4 got=%h exp=11", beat_data[4]); end
      checks++; if (beat_data[5] !== 8'h21 || beat_last[5] !== 1'b1) begin failures++; $display("FAIL early_beat5 got=%h/%b exp=21/1", beat_data[5], beat_last[5]); end
      checks++; if (beat_last[2] !== 1'b0) begin failures++; $display("FAIL early_last_on_beat2 got=%b exp=0", beat_last[2]); end
    end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL early_frame_err got=%b exp=1", frame_err); end
    clear_obs();
    drive_frame(5, 8'h80, 4, 3);
    checks++; if (beat_data.size() != 30) begin failures++; $display("FAIL early_next_count got=%0d exp=30", beat_data.size()); end
    if (beat_data.size() >= 3) begin
      checks++;
      if (beat_data[0] !== 8'h80 || beat_data[1] !== 8'h90 || beat_data[2] !== 8'hA0) begin
        failures++;
        $display("FAIL early_next_col got=%h,%h,%h exp=80,90,a0", beat_data[0], beat_data[1], beat_data[2]);
      end
    end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL early_err_sticky got=%b exp=1", frame_err); end
    @(negedge clk); soft_reset = 1'b1;
    @(negedge clk);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL soft_reset_err got=%b exp=0", frame_err); end
    checks++; if (s_axis_ready !== 1'b0) begin failures++; $display("FAIL soft_reset_ready got=%b exp=0", s_axis_ready); end
    soft_reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("test_early_last done");
  endtask

  task automatic test_bad_config();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    img_width = 16'd2; enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_w2 got=%b exp=1", cfg_err); end
    checks++; if (s_axis_ready !== 1'b0) begin failures++; $display("FAIL cfg_ready_w2 got=%b exp=0", s_axis_ready); end
    img_width = 16'd25; img_height = 16'd25;
    #1;
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_w25 got=%b exp=0", cfg_err); end
    clear_obs();
    drive_frame(25, 0, 24, 24);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL cfg_timeout got=%b exp=0", timed_out); end
    checks++; if (beat_data.size() != 1725) begin failures++; $display("FAIL cfg_count got=%0d exp=1725", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 1725; i++) begin
      checks++;
      if (beat_data[i] !== exp_beat(25, 0, i) || beat_last[i] !== (i == 1724)) begin
        failures++;
        $display("FAIL cfg_beat%0d got=%h/%b exp=%h/%b", i, beat_data[i], beat_last[i], exp_beat(25, 0, i), i == 1724);
      end
    end
    checks++; if (done_at.size() != 1) begin failures++; $display("FAIL cfg_done got=%0d exp=1", done_at.size()); end
    img_width = 16'd5; img_height = 16'd4;
    $display("test_bad_config beats=%0d", beat_data.size());
  endtask

  task automatic test_reset_mid_emit();
    clear_obs();
    rst_at = 1;
    drive_frame(5, 0, 4, 3);
    checks++; if (rst_fired !== 1'b1 || rst_pre_valid !== 1'b1) begin failures++; $display("FAIL rst_emit_reached got=%b/%b exp=1/1", rst_fired, rst_pre_valid); end
    checks++; if (rst_valid !== 1'b0) begin failures++; $display("FAIL rst_emit_valid got=%b exp=0", rst_valid); end
    checks++; if (rst_data !== 8'h00) begin failures++; $display("FAIL rst_emit_data got=%h exp=00", rst_data); end
    checks++; if (rst_last !== 1'b0 || rst_sready !== 1'b0) begin failures++; $display("FAIL rst_emit_last_ready got=%b/%b exp=0/0", rst_last, rst_sready); end
    checks++; if (rst_done !== 1'b0 || rst_err !== 1'b0) begin failures++; $display("FAIL rst_emit_done_err got=%b/%b exp=0/0", rst_done, rst_err); end
    @(negedge clk); axi_reset_n = 1'b1;
    clear_obs();
    drive_frame(5, 0, 4, 3);
    checks++; if (beat_data.size() != 30) begin failures++; $display("FAIL rst_fresh_count got=%0d exp=30", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 30; i++) begin
      checks++;
      if (beat_data[i] !== exp_beat(5, 0, i) || beat_last[i] !== (i == 29)) begin
        failures++;
        $display("FAIL rst_fresh_beat%0d got=%h/%b exp=%h/%b", i, beat_data[i], beat_last[i], exp_beat(5, 0, i), i == 29);
      end
    end
    checks++; if (done_at.size() != 1) begin failures++; $display("FAIL rst_fresh_done got=%0d exp=1", done_at.size()); end
    $display("test_reset_mid_emit beats=%0d", beat_data.size());
  endtask

  task automatic test_enable_toggle();
    clear_obs();
    en_drop_at = 9;
    drive_frame(5, 0, 4, 3);
    checks++; if (en_obs.size() != 5) begin failures++; $display("FAIL en_idle_cycles got=%0d exp=5", en_obs.size()); end
    for (int i = 0; i < en_obs.size(); i++) begin
      checks++;
      if (en_obs[i] !== 1'b0) begin failures++; $display("FAIL en_ready%0d got=%b exp=0", i, en_obs[i]); end
    end
    checks++; if (beat_data.size() != 30) begin failures++; $display("FAIL en_count got=%0d exp=30", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 30; i++) begin
      checks++;
      if (beat_data[i] !== exp_beat(5, 0, i) || beat_last[i] !== (i == 29)) begin
        failures++;
        $display("FAIL en_beat%0d got=%h/%b exp=%h/%b", i, beat_data[i], beat_last[i], exp_beat(5, 0, i), i == 29);
      end
    end
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL en_reenabled got=%b exp=1", enable); end
    $display("test_enable_toggle beats=%0d", beat_data.size());
  endtask

  initial begin
    axi_reset_n = 1'b0; enable = 1'b1; soft_reset = 1'b0;
    img_width = 16'd5; img_height = 16'd4;
    s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0; s_axis_keep = '1;
    m_axis_ready = 1'b1;
    clear_obs();
    test_reset();
    test_basic_frame();
    test_back_pressure();
    test_early_last();
    test_bad_config();
    test_reset_mid_emit();
    test_enable_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
